// File: rtl/inv_sqrt_bridge_pkg.sv
// Shared definitions for the inverse-square-root Wishbone bridge: register map,
// STATUS/CTRL bit positions and the issue FSM state type.
package inv_sqrt_bridge_pkg;

    // Register select values (wb_adr_i[3:2])
    localparam logic [1:0] REG_OPERAND = 2'd0;
    localparam logic [1:0] REG_RESULT  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_OP_FULL       = 0;
    localparam int ST_OP_EMPTY      = 1;
    localparam int ST_RES_FULL      = 2;
    localparam int ST_RES_EMPTY     = 3;
    localparam int ST_BUSY          = 4;
    localparam int ST_OVERFLOW      = 5;
    localparam int ST_UNDERFLOW     = 6;
    localparam int ST_OP_COUNT_LSB  = 8;
    localparam int ST_RES_COUNT_LSB = 16;

    localparam int CTRL_IRQ_EN    = 0;
    localparam int CTRL_OVERFLOW  = 5;
    localparam int CTRL_UNDERFLOW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESULT
    } issue_state_t;

endpackage

// File: rtl/inv_sqrt_wb_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are
// ignored, and full/empty are evaluated before any same-cycle push/pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem_reg[rd_ptr_reg];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Storage kept out of the reset branch so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/inv_sqrt_wb_bridge.sv
// Wishbone front end feeding one operand at a time to the inverse-sqrt core and
// queueing its results; INV_SQRT_BRIDGE_IRQ_EN enables the result interrupt.
module inv_sqrt_wb_bridge
    import inv_sqrt_bridge_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic [WORD_WIDTH-1:0] core_data_o,
    output logic                  core_valid_o,
    input  logic                  core_ready_i,
    input  logic [WORD_WIDTH-1:0] core_data_i,
    input  logic                  core_valid_i,
    output logic                  core_ready_o,
    output logic                  irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    issue_state_t          state_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  irq_en;

    logic                  wb_access;
    logic                  wr_access;
    logic                  rd_access;
    logic [1:0]            reg_sel;

    logic                  op_push, op_pop, op_full, op_empty;
    logic [WORD_WIDTH-1:0] op_head;
    logic [CW-1:0]         op_count;
    logic                  res_push, res_pop, res_full, res_empty;
    logic [WORD_WIDTH-1:0] res_head;
    logic [CW-1:0]         res_count;

    logic [31:0]           status_word;
    logic [31:0]           ctrl_word;
    logic                  unused_bits;

    // An access is taken once, on the edge that raises ack
    assign wb_access = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wr_access = wb_access && wb_we_i;
    assign rd_access = wb_access && !wb_we_i;
    assign reg_sel   = wb_adr_i[3:2];

    assign op_push      = wr_access && (reg_sel == REG_OPERAND);
    assign res_pop      = rd_access && (reg_sel == REG_RESULT);
    assign op_pop       = (state_reg == S_ISSUE) && core_valid_o && core_ready_i;
    assign core_ready_o = (state_reg == S_WAIT_RESULT) && !res_full;
    assign res_push     = (state_reg == S_WAIT_RESULT) && core_valid_i && core_ready_o;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

    sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (op_push),
        .push_data (wb_dat_i[WORD_WIDTH-1:0]),
        .pop       (op_pop),
        .pop_data  (op_head),
        .full      (op_full),
        .empty     (op_empty),
        .count     (op_count)
    );

    sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_push),
        .push_data (core_data_i),
        .pop       (res_pop),
        .pop_data  (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    // Issue FSM: one operand in flight; core_data_o latched on entry to ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            core_valid_o <= 1'b0;
            core_data_o  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!op_empty) begin
                        state_reg    <= S_ISSUE;
                        core_valid_o <= 1'b1;
                        core_data_o  <= op_head;
                    end
                end
                S_ISSUE: begin
                    if (core_ready_i) begin
                        state_reg    <= S_WAIT_RESULT;
                        core_valid_o <= 1'b0;
                    end
                end
                S_WAIT_RESULT: begin
                    if (res_push) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    core_valid_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        status_word = '0;
        status_word[ST_OP_FULL]   = op_full;
        status_word[ST_OP_EMPTY]  = op_empty;
        status_word[ST_RES_FULL]  = res_full;
        status_word[ST_RES_EMPTY] = res_empty;
        status_word[ST_BUSY]      = (state_reg != S_IDLE);
        status_word[ST_OVERFLOW]  = overflow_reg;
        status_word[ST_UNDERFLOW] = underflow_reg;
        status_word[ST_OP_COUNT_LSB +: 8]  = 8'(op_count);
        status_word[ST_RES_COUNT_LSB +: 8] = 8'(res_count);
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_IRQ_EN]    = irq_en;
        ctrl_word[CTRL_OVERFLOW]  = overflow_reg;
        ctrl_word[CTRL_UNDERFLOW] = underflow_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o      <= 1'b0;
            wb_dat_o      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
            wb_dat_o <= '0;
            if (rd_access) begin
                case (reg_sel)
                    REG_RESULT: wb_dat_o <= res_empty ? '0 : 32'(res_head);
                    REG_STATUS: wb_dat_o <= status_word;
                    REG_CTRL:   wb_dat_o <= ctrl_word;
                    default:    wb_dat_o <= '0;
                endcase
            end
            if (op_push && op_full) overflow_reg <= 1'b1;
            if (res_pop && res_empty) underflow_reg <= 1'b1;
            if (wr_access && (reg_sel == REG_CTRL)) begin
                if (wb_dat_i[CTRL_OVERFLOW])  overflow_reg  <= 1'b0;
                if (wb_dat_i[CTRL_UNDERFLOW]) underflow_reg <= 1'b0;
            end
        end
    end

`ifdef INV_SQRT_BRIDGE_IRQ_EN
    logic          irq_en_reg;
    logic          irq_en_next;
    logic [CW-1:0] res_count_next;

    // Look ahead one cycle so irq_o tracks the FIFO occupancy without extra lag
    always_comb begin
        irq_en_next    = (wr_access && (reg_sel == REG_CTRL)) ? wb_dat_i[CTRL_IRQ_EN] : irq_en_reg;
        res_count_next = res_count + CW'(res_push) - CW'(res_pop && !res_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_reg <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            irq_en_reg <= irq_en_next;
            irq_o      <= irq_en_next && (res_count_next != '0);
        end
    end

    assign irq_en = irq_en_reg;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sqrt_wb_bridge.sv
// Directed bench for inv_sqrt_wb_bridge with a behavioural core model that
// answers with hand-computed Q12.4 inverse square roots.
module tb_inv_sqrt_wb_bridge;

`ifdef INV_SQRT_BRIDGE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [15:0] core_data_o;
    logic        core_valid_o;
    logic        core_ready_i;
    logic [15:0] core_data_i;
    logic        core_valid_i;
    logic        core_ready_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    // Core model state
    int          cm_state;
    int          cm_cnt;
    int          cm_lat;
    logic        cm_allow;
    logic        cm_hold;
    logic [15:0] cm_res;
    logic        hs_in, hs_out;
    int          issue_count = 0;
    int          cap_count   = 0;
    int          proto_err   = 0;

    always #5 clk = ~clk;

    inv_sqrt_wb_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_we_i      (wb_we_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .core_data_o  (core_data_o),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i),
        .core_ready_o (core_ready_o),
        .irq_o        (irq_o)
    );

    function automatic logic [15:0] isqrt_ref(input logic [15:0] x);
        case (x)
            16'h0010: return 16'h0010;  // 1.0  -> 1.0
            16'h0040: return 16'h0008;  // 4.0  -> 0.5
            16'h0100: return 16'h0004;  // 16.0 -> 0.25
            16'h0190: return 16'h0003;  // 25.0 -> 0.2
            default:  return 16'hDEAD;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] q);
        int n;
        @(negedge clk);
        wb_adr_i = a;
        wb_we_i  = we;
        wb_dat_i = d;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 8);
        q = wb_dat_o;
        chk("wb_ack", {31'b0, wb_ack_o}, 32'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        $display("WB %s adr=0x%h dat=0x%08h", we ? "WR" : "RD", a, we ? d : q);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(a, 1'b1, d, q);
    endtask

    task automatic wb_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(a, 1'b0, 32'h0, q);
        chk(tag, q, exp);
    endtask

    task automatic wait_caps(input int target, input string tag);
        int n;
        n = 0;
        while (cap_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cap_count, target);
    endtask

    // Core model: samples handshakes at the rising edge, drives on the falling edge
    initial begin
        core_ready_i = 1'b0;
        core_valid_i = 1'b0;
        core_data_i  = '0;
        cm_state     = 0;
        cm_cnt       = 0;
        cm_res       = '0;
        forever begin
            @(posedge clk);
            hs_in  = core_valid_o && core_ready_i;
            hs_out = core_valid_i && core_ready_o;
            if (hs_in) begin
                if (issue_count != cap_count) proto_err++;
                issue_count++;
                cm_res = isqrt_ref(core_data_o);
            end
            if (hs_out) cap_count++;
            @(negedge clk);
            if (rst) begin
                cm_state     = 0;
                core_ready_i = 1'b0;
                core_valid_i = 1'b0;
            end else begin
                case (cm_state)
                    0: begin
                        if (hs_in) begin
                            core_ready_i = 1'b0;
                            cm_cnt       = cm_lat;
                            cm_state     = 1;
                        end else begin
                            core_ready_i = cm_allow;
                        end
                    end
                    1: begin
                        if (cm_cnt <= 1) begin
                            core_valid_i = 1'b1;
                            core_data_i  = cm_res;
                            cm_state     = 2;
                        end else begin
                            cm_cnt--;
                        end
                    end
                    2: begin
                        if (hs_out) begin
                            if (cm_hold) begin
                                cm_hold  = 1'b0;
                                cm_state = 3;
                            end else begin
                                core_valid_i = 1'b0;
                                core_ready_i = cm_allow;
                                cm_state     = 0;
                            end
                        end
                    end
                    default: begin
                        core_valid_i = 1'b0;
                        core_ready_i = cm_allow;
                        cm_state     = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        cm_allow = 1'b0;
        cm_hold  = 1'b0;
        cm_lat   = 4;
        repeat (3) @(negedge clk);

        chk("rst_ack",        {31'b0, wb_ack_o}, 32'd0);
        chk("rst_dat",        wb_dat_o, 32'd0);
        chk("rst_core_valid", {31'b0, core_valid_o}, 32'd0);
        chk("rst_core_data",  {16'b0, core_data_o}, 32'd0);
        chk("rst_core_ready", {31'b0, core_ready_o}, 32'd0);
        chk("rst_irq",        {31'b0, irq_o}, 32'd0);
        rst = 1'b0;

        wb_read_chk("status_reset", 4'h8, 32'h0000_000A);
        wb_write(4'hC, 32'h1);
        wb_read_chk("ctrl_irq_en", 4'hC, {31'b0, IRQ_ON});

        // Single operand 4.0 -> 0.5
        cm_allow = 1'b1;
        wb_write(4'h0, 32'h0040);
        wait_caps(1, "cap_single");
        chk("irq_after_capture", {31'b0, irq_o}, {31'b0, IRQ_ON});
        wb_read_chk("result_single", 4'h4, 32'h0000_0008);
        chk("irq_after_drain", {31'b0, irq_o}, 32'd0);
        wb_read_chk("status_after_single", 4'h8, 32'h0000_000A);

        // Three operands with the core stalled for 10 cycles
        cm_allow = 1'b0;
        wb_write(4'h0, 32'h0010);
        wb_write(4'h0, 32'h0040);
        wb_write(4'h0, 32'h0190);
        repeat (10) @(negedge clk);
        chk("stall_core_valid", {31'b0, core_valid_o}, 32'd1);
        chk("stall_core_data", {16'b0, core_data_o}, 32'h0010);
        wb_read_chk("status_stalled", 4'h8, 32'h0000_0318);
        cm_allow = 1'b1;
        wait_caps(4, "cap_three");
        wb_read_chk("result_order0", 4'h4, 32'h0000_0010);
        wb_read_chk("result_order1", 4'h4, 32'h0000_0008);
        wb_read_chk("result_order2", 4'h4, 32'h0000_0003);
        chk("one_outstanding", proto_err, 0);

        // Overflow: five writes while the core refuses operands
        cm_allow = 1'b0;
        wb_write(4'h0, 32'h0010);
        wb_write(4'h0, 32'h0040);
        wb_write(4'h0, 32'h0100);
        wb_write(4'h0, 32'h0190);
        wb_write(4'h0, 32'h0040);
        wb_read_chk("status_overflow", 4'h8, 32'h0000_0439);
        wb_write(4'hC, 32'h21);
        wb_read_chk("status_ovf_clear", 4'h8, 32'h0000_0419);

        // Drain into the result FIFO until it is full
        cm_allow = 1'b1;
        wait_caps(8, "cap_fill");
        wb_read_chk("status_res_full", 4'h8, 32'h0004_0006);
        chk("irq_res_full", {31'b0, irq_o}, {31'b0, IRQ_ON});
        wb_write(4'h0, 32'h0100);
        repeat (12) @(negedge clk);
        chk("ready_low_when_full", {31'b0, core_ready_o}, 32'd0);
        chk("no_capture_when_full", cap_count, 8);
        wb_read_chk("status_blocked", 4'h8, 32'h0004_0016);

        // Free one slot; core then holds valid for an extra cycle
        cm_hold = 1'b1;
        wb_read_chk("result_fill0", 4'h4, 32'h0000_0010);
        wait_caps(9, "cap_after_pop");
        repeat (4) @(negedge clk);
        chk("no_double_capture", cap_count, 9);
        wb_read_chk("status_refilled", 4'h8, 32'h0004_0006);
        wb_read_chk("result_fill1", 4'h4, 32'h0000_0008);
        wb_read_chk("result_fill2", 4'h4, 32'h0000_0004);
        wb_read_chk("result_fill3", 4'h4, 32'h0000_0003);
        wb_read_chk("result_fill4", 4'h4, 32'h0000_0004);
        chk("irq_after_last_read", {31'b0, irq_o}, 32'd0);

        // Underflow on an empty result FIFO
        wb_read_chk("result_empty", 4'h4, 32'h0000_0000);
        wb_read_chk("status_underflow", 4'h8, 32'h0000_004A);
        chk("one_outstanding_final", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
